// File: rtl/alu_op_instr_encoder_pkg.sv
// Shared definitions for the ALU-op instruction encoder: RV32I opcodes, funct fields,
// the 4-bit ALU operation codes agreed with ALU control, and the loader FSM states.
package alu_op_instr_encoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_LUI = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101
    } alu_op_e;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WRITE,
        ST_FULL,
        ST_DONE
    } enc_state_e;

    function automatic logic [31:0] rTypeWord(input logic [6:0] f7, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] f3,
                                              input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_R};
    endfunction

    // Shift immediates reuse this with {funct7, shamt} as the 12-bit field.
    function automatic logic [31:0] iTypeWord(input logic [11:0] imm12, input logic [4:0] rs1,
                                              input logic [2:0] f3, input logic [4:0] rd);
        return {imm12, rs1, f3, rd, OPC_I};
    endfunction

endpackage

// File: rtl/alu_op_instr_encoder_instr_word_encoder.sv
// Combinational encoder: ALU request fields in, 32-bit RV32I word plus legality flag out.
module instr_word_encoder (
    input  logic [3:0]  alu_op_i,
    input  logic        imm_sel_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [19:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);
    import alu_op_instr_encoder_pkg::*;

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (alu_op_i)
            ALU_ADD: begin
                legal_o = 1'b1;
                word_o  = imm_sel_i ? iTypeWord(imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i)
                                    : rTypeWord(F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i);
            end
            ALU_SUB: begin
                legal_o = ~imm_sel_i;
                word_o  = rTypeWord(F7_SUB, rs2_i, rs1_i, F3_ADD_SUB, rd_i);
            end
            ALU_LUI: begin
                legal_o = 1'b1;
                word_o  = {imm_i, rd_i, OPC_LUI};
            end
            ALU_OR: begin
                legal_o = imm_sel_i;
                word_o  = iTypeWord(imm_i[11:0], rs1_i, F3_OR, rd_i);
            end
            // Upper shift-immediate bits are dropped, not flagged.
            ALU_SLL: begin
                legal_o = imm_sel_i;
                word_o  = iTypeWord({F7_BASE, imm_i[4:0]}, rs1_i, F3_SLL, rd_i);
            end
            ALU_SRL: begin
                legal_o = imm_sel_i;
                word_o  = iTypeWord({F7_BASE, imm_i[4:0]}, rs1_i, F3_SRL, rd_i);
            end
            default: begin
                legal_o = 1'b0;
                word_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_instr_encoder.sv
// Program loader: accepts ALU requests, encodes them and writes one word every two cycles
// into instruction memory starting at BASE_ADDR, stopping at DEPTH words or on finish.
module alu_op_instr_encoder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          finish_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [3:0]    alu_op_i,
    input  logic          imm_sel_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [19:0]   imm_i,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [CW-1:0] count_o,
    output logic          err_o,
    output logic [7:0]    err_cnt_o,
    output logic          full_o,
    output logic          done_o
);
    import alu_op_instr_encoder_pkg::*;

    enc_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    errCnt_q, errCnt_d;
    logic          err_q, err_d;
    logic [31:0]   word_q, word_d;
    logic          finSeen_q, finSeen_d;

    logic [31:0]   encWord;
    logic          encLegal;

    instr_word_encoder u_encoder (
        .alu_op_i  (alu_op_i),
        .imm_sel_i (imm_sel_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .word_o    (encWord),
        .legal_o   (encLegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            count_q   <= '0;
            errCnt_q  <= '0;
            err_q     <= 1'b0;
            word_q    <= '0;
            finSeen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            errCnt_q  <= errCnt_d;
            err_q     <= err_d;
            word_q    <= word_d;
            finSeen_q <= finSeen_d;
        end
    end

    // finish_i arriving with a legal request is remembered so the word lands before DONE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        errCnt_d  = errCnt_q;
        err_d     = 1'b0;
        word_d    = word_q;
        finSeen_d = finSeen_q;
        case (state_q)
            ST_LOAD: begin
                if (req_valid_i) begin
                    if (encLegal) begin
                        word_d    = encWord;
                        finSeen_d = finish_i;
                        state_d   = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (errCnt_q != 8'hFF) begin
                            errCnt_d = errCnt_q + 8'd1;
                        end
                        if (finish_i) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (finish_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                count_d   = count_q + CW'(1);
                finSeen_d = 1'b0;
                if (count_d == CW'(DEPTH)) begin
                    state_d = ST_FULL;
                end else if (finSeen_q || finish_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FULL, ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    count_d  = '0;
                    errCnt_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign req_ready_o = (state_q == ST_LOAD);
    assign mem_we_o    = (state_q == ST_WRITE);
    assign mem_addr_o  = BASE_ADDR + (32'(count_q) << 2);
    assign mem_wdata_o = word_q;
    assign count_o     = count_q;
    assign err_o       = err_q;
    assign err_cnt_o   = errCnt_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_op_instr_encoder.sv
// Self-checking bench for alu_op_instr_encoder: directed program-loader scenarios plus
// randomized traffic compared every cycle against a behavioural model of the loader.
module tb_alu_op_instr_encoder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    localparam int M_LOAD  = 0;
    localparam int M_WRITE = 1;
    localparam int M_FULL  = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic        finish_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [3:0]  alu_op_i = '0;
    logic        imm_sel_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [19:0] imm_i = '0;

    logic        req_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [6:0]  count_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;
    logic        full_o;
    logic        done_o;

    int tests = 0;
    int fails = 0;

    alu_op_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .finish_i    (finish_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .alu_op_i    (alu_op_i),
        .imm_sel_i   (imm_sel_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .count_o     (count_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o),
        .full_o      (full_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built straight from the RV32I field layout.
    function automatic bit refEncode(input logic [3:0] op, input logic sel, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [19:0] imm, output logic [31:0] w);
        logic [31:0] top12;
        logic [31:0] f3;
        logic [31:0] opc;
        w = 32'd0;
        top12 = 32'd0;
        f3 = 32'd0;
        opc = 32'h13;
        case (op)
            4'd0: begin
                if (sel) top12 = 32'(imm[11:0]);
                else begin top12 = 32'(rs2); opc = 32'h33; end
            end
            4'd1: begin
                if (sel) return 1'b0;
                top12 = 32'h400 + 32'(rs2);
                opc = 32'h33;
            end
            4'd2: begin
                w = (32'(imm) << 12) | (32'(rd) << 7) | 32'h37;
                return 1'b1;
            end
            4'd3: begin
                if (!sel) return 1'b0;
                top12 = 32'(imm[11:0]);
                f3 = 32'd6;
            end
            4'd4: begin
                if (!sel) return 1'b0;
                top12 = 32'(imm[4:0]);
                f3 = 32'd1;
            end
            4'd5: begin
                if (!sel) return 1'b0;
                top12 = 32'(imm[4:0]);
                f3 = 32'd5;
            end
            default: return 1'b0;
        endcase
        w = (top12 << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | opc;
        return 1'b1;
    endfunction

    int          mMode;
    int          mCount;
    int          mErrCnt;
    bit          mErr;
    bit          mFin;
    logic [31:0] mWord;
    bit          modelOn = 1'b0;

    always @(negedge rst_n) begin
        mMode   = M_LOAD;
        mCount  = 0;
        mErrCnt = 0;
        mErr    = 1'b0;
        mFin    = 1'b0;
        mWord   = 32'd0;
        modelOn = 1'b1;
    end

    // Model of the loader's observable behaviour, advanced once per rising edge.
    always @(posedge clk) begin
        if (rst_n && modelOn) begin
            logic [31:0] w;
            bit          legal;
            mErr = 1'b0;
            case (mMode)
                M_LOAD: begin
                    if (req_valid_i) begin
                        legal = refEncode(alu_op_i, imm_sel_i, rd_i, rs1_i, rs2_i, imm_i, w);
                        if (legal) begin
                            mWord = w;
                            mFin  = finish_i;
                            mMode = M_WRITE;
                        end else begin
                            mErr = 1'b1;
                            if (mErrCnt < 255) mErrCnt++;
                            if (finish_i) mMode = M_DONE;
                        end
                    end else if (finish_i) begin
                        mMode = M_DONE;
                    end
                end
                M_WRITE: begin
                    mCount++;
                    if (mCount == DEPTH) mMode = M_FULL;
                    else if (mFin || finish_i) mMode = M_DONE;
                    else mMode = M_LOAD;
                    mFin = 1'b0;
                end
                default: begin
                    if (start_i) begin
                        mMode   = M_LOAD;
                        mCount  = 0;
                        mErrCnt = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && modelOn) begin
            checkOutput("ready", 32'(req_ready_o), 32'(mMode == M_LOAD));
            checkOutput("we", 32'(mem_we_o), 32'(mMode == M_WRITE));
            checkOutput("addr", mem_addr_o, BASE + 32'(4 * mCount));
            checkOutput("wdata", mem_wdata_o, mWord);
            checkOutput("count", 32'(count_o), 32'(mCount));
            checkOutput("err", 32'(err_o), 32'(mErr));
            checkOutput("err_cnt", 32'(err_cnt_o), 32'(mErrCnt));
            checkOutput("full", 32'(full_o), 32'(mCount == DEPTH));
            checkOutput("done", 32'(done_o), 32'(mMode == M_DONE));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut;
        req_valid_i = 1'b0;
        finish_i = 1'b0;
        start_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic sel, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [19:0] imm, input logic fin);
        int t = 0;
        alu_op_i = op;
        imm_sel_i = sel;
        rd_i = rd;
        rs1_i = rs1;
        rs2_i = rs2;
        imm_i = imm;
        req_valid_i = 1'b1;
        while (!req_ready_o && t < 20) begin
            tick();
            t++;
        end
        if (!req_ready_o) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got ready=0, expected ready=1 within 20 cycles");
        end
        finish_i = fin;
        tick();
        req_valid_i = 1'b0;
        finish_i = 1'b0;
    endtask

    task automatic randomLegal(output logic [3:0] op, output logic sel);
        op = 4'($urandom_range(0, 5));
        case (op)
            4'd0, 4'd2: sel = 1'($urandom);
            4'd1:       sel = 1'b0;
            default:    sel = 1'b1;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic       sel;
        logic       v;

        #1;
        resetDut();
        tick();
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_addr", mem_addr_o, 32'h0040_0000);
        checkOutput("rst_we", 32'(mem_we_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);

        applyStimulus(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0, 1'b0);
        checkOutput("add_we", 32'(mem_we_o), 32'd1);
        checkOutput("add_addr", mem_addr_o, 32'h0040_0000);
        checkOutput("add_word", mem_wdata_o, 32'h002081B3);

        resetDut();
        applyStimulus(4'b0000, 1'b1, 5'd5, 5'd0, 5'd0, 20'h00FFF, 1'b0);
        checkOutput("addi_addr", mem_addr_o, 32'h0040_0000);
        checkOutput("addi_word", mem_wdata_o, 32'hFFF00293);
        applyStimulus(4'b0001, 1'b0, 5'd4, 5'd3, 5'd2, 20'd0, 1'b0);
        checkOutput("sub_addr", mem_addr_o, 32'h0040_0004);
        checkOutput("sub_word", mem_wdata_o, 32'h40218233);

        resetDut();
        applyStimulus(4'b0010, 1'b0, 5'd10, 5'd0, 5'd0, 20'h10010, 1'b0);
        checkOutput("lui_word", mem_wdata_o, 32'h10010537);
        applyStimulus(4'b0101, 1'b1, 5'd6, 5'd6, 5'd0, 20'h00FE4, 1'b0);
        checkOutput("srli_word", mem_wdata_o, 32'h00435313);
        tick();
        checkOutput("count_two", 32'(count_o), 32'd2);

        applyStimulus(4'b0001, 1'b1, 5'd4, 5'd3, 5'd2, 20'd0, 1'b0);
        checkOutput("ill_err", 32'(err_o), 32'd1);
        checkOutput("ill_errcnt", 32'(err_cnt_o), 32'd1);
        checkOutput("ill_we", 32'(mem_we_o), 32'd0);
        checkOutput("ill_ready", 32'(req_ready_o), 32'd1);
        checkOutput("ill_count", 32'(count_o), 32'd2);

        resetDut();
        for (int k = 0; k < DEPTH; k++) begin
            randomLegal(op, sel);
            applyStimulus(op, sel, 5'($urandom), 5'($urandom), 5'($urandom), 20'($urandom), 1'b0);
        end
        checkOutput("last_addr", mem_addr_o, 32'h0040_00FC);
        tick();
        checkOutput("full_flag", 32'(full_o), 32'd1);
        checkOutput("full_ready", 32'(req_ready_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checkOutput("restart_count", 32'(count_o), 32'd0);
        applyStimulus(4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0);
        checkOutput("restart_addr", mem_addr_o, 32'h0040_0000);

        resetDut();
        applyStimulus(4'b0011, 1'b1, 5'd7, 5'd8, 5'd0, 20'h00123, 1'b1);
        checkOutput("fin_we", 32'(mem_we_o), 32'd1);
        tick();
        checkOutput("fin_done", 32'(done_o), 32'd1);

        resetDut();
        applyStimulus(4'b0000, 1'b0, 5'd1, 5'd1, 5'd1, 20'd0, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b1, 5'd2, 5'd2, 5'd0, 20'd3, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstw_we", 32'(mem_we_o), 32'd0);
        checkOutput("rstw_count", 32'(count_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic including illegal ops, restarts and finish pulses.
        for (int c = 0; c < 600; c++) begin
            v = 1'($urandom);
            req_valid_i = v;
            alu_op_i = 4'($urandom_range(0, 7));
            imm_sel_i = 1'($urandom);
            rd_i = 5'($urandom);
            rs1_i = 5'($urandom);
            rs2_i = 5'($urandom);
            imm_i = 20'($urandom);
            start_i = ($urandom_range(0, 11) == 0);
            finish_i = !v && ($urandom_range(0, 39) == 0);
            tick();
        end
        req_valid_i = 1'b0;
        start_i = 1'b0;
        finish_i = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
